// File: rtl/display_mux_ctrl_pkg.sv
// display_mux_pkg: shared types and constants for the dual-digit display
// multiplexer.
//   mux_state_t      : FSM state encoding (ON0, BLANK0, ON1, BLANK1)
//   AN_OFF/AN_D0/AN_D1 : active-low digit-enable patterns
package display_mux_pkg;

   typedef enum logic [1:0] {
      ON0    = 2'd0,
      BLANK0 = 2'd1,
      ON1    = 2'd2,
      BLANK1 = 2'd3
   } mux_state_t;

   localparam logic [1:0] AN_OFF = 2'b11;
   localparam logic [1:0] AN_D0  = 2'b10;
   localparam logic [1:0] AN_D1  = 2'b01;

endpackage

// File: rtl/display_mux_ctrl_if.sv
// display_mux_ctrl_if: signal bundle between the switch inputs, the shared
// seven-segment decoder path and the display multiplexer.
//   s1, s2   : switch nibbles for digit 0 / digit 1 (already synchronized)
//   seg_sel  : nibble presented to the shared decoder
//   an       : active-low digit enables, an[0] = digit 0, an[1] = digit 1
//   digit    : index of the digit seg_sel belongs to
//   sum      : registered s1 + s2 for the LED bar
//   state    : current FSM state, exported for observation
// No handshake: every signal is a level, sampled or updated on each clk edge.
// slave modport is the multiplexer; master modport is its environment.
interface display_mux_ctrl_if;
   import display_mux_pkg::*;

   logic [3:0] s1;
   logic [3:0] s2;
   logic [3:0] seg_sel;
   logic [1:0] an;
   logic       digit;
   logic [4:0] sum;
   mux_state_t state;

   modport master (
      output s1, s2,
      input  seg_sel, an, digit, sum, state
   );

   modport slave (
      input  s1, s2,
      output seg_sel, an, digit, sum, state
   );

endinterface

// File: rtl/display_mux_ctrl_dwell_timer.sv
// dwell_timer: counts clocks since the last clear.
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the count from zero on the next edge
//   limit      : dwell length in clocks (W+1 bits so the full dwell fits)
//   done       : high while count == limit-1 (last clock of the dwell)
module dwell_timer #(
   parameter int W = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic [W:0] limit,
   output logic       done
);

   localparam int LW = W + 1;

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

   assign done = ({1'b0, count} == (limit - LW'(1)));

endmodule

// File: rtl/display_mux_ctrl.sv
// display_mux_ctrl: time-multiplexes one seven-segment decoder between two
// digits, with a blanking interval around every digit change, and registers
// s1 + s2 for the LED bar.
//   clk, reset : clock and synchronous active-high reset
//   bus        : display_mux_ctrl_if.slave (s1/s2 in; seg_sel, an, digit,
//                sum, state out)
// Parameters: ON_CYCLES (clocks per digit visit, >= 1) and BLANK_CYCLES
// (clocks with both digits off between visits, >= 1).
module display_mux_ctrl
   import display_mux_pkg::*;
#(
   parameter int ON_CYCLES    = 24000,
   parameter int BLANK_CYCLES = 240
) (
   input  logic                 clk,
   input  logic                 reset,
   display_mux_ctrl_if.slave    bus
);

   localparam int MAX_DWELL = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
   localparam int CW        = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
   localparam int LW        = CW + 1;

   mux_state_t    state;
   logic [1:0]    an_q;
   logic [3:0]    seg_q;
   logic          digit_q;
   logic [4:0]    sum_q;
   logic [LW-1:0] limit;
   logic          done;

   assign limit = ((state == ON0) || (state == ON1)) ? LW'(ON_CYCLES) : LW'(BLANK_CYCLES);

   // The timer clears itself on the same edge the FSM leaves a state, so
   // the count always restarts from zero on state entry.
   dwell_timer #(.W(CW)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (done),
      .limit (limit),
      .done  (done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= BLANK1;
         an_q    <= AN_OFF;
         seg_q   <= 4'h0;
         digit_q <= 1'b0;
         sum_q   <= 5'h0;
      end else begin
         sum_q <= {1'b0, bus.s1} + {1'b0, bus.s2};
         if (done) begin
            case (state)
               ON0: begin
                  state <= BLANK0;
                  an_q  <= AN_OFF;
               end
               BLANK0: begin
                  // Nibble is captured only on window entry so it stays
                  // stable for the whole visit.
                  state   <= ON1;
                  an_q    <= AN_D1;
                  seg_q   <= bus.s2;
                  digit_q <= 1'b1;
               end
               ON1: begin
                  state <= BLANK1;
                  an_q  <= AN_OFF;
               end
               default: begin
                  state   <= ON0;
                  an_q    <= AN_D0;
                  seg_q   <= bus.s1;
                  digit_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.state   = state;
   assign bus.an      = an_q;
   assign bus.seg_sel = seg_q;
   assign bus.digit   = digit_q;
   assign bus.sum     = sum_q;

endmodule
